// File: rtl/exec_unit_pkg.sv
// Shared decoder types for the execution unit.
// Contents: default datapath/register-file sizes, opcode enum, FSM state enum,
// and a helper that classifies single-cycle register-writing opcodes.
package exec_unit_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_NREGS = 16;
    localparam int unsigned OP_W      = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_MUL = 4'd7,
        OP_RET = 4'd8
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Opcodes that complete in one cycle and write reg[dst].
    function automatic logic op_is_alu(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   start            load operands; first partial product is taken on this edge
//   a, b             WIDTH-bit unsigned operands (sampled when start is high)
//   done             high for one cycle once product holds the full result
//   product          2*WIDTH-bit accumulated product
// The start edge performs step 1, so after WIDTH-1 further edges the product is
// complete and done is visible exactly WIDTH edges after start.
module seq_mul
    import exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [PW-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q,    acc_d;

    // Next-state: load on start, otherwise one shift-add step per busy cycle.
    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            acc_d    = b[0] ? PW'(a) : '0;
            mcand_d  = PW'(a) << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/exec_unit.sv
// Small register-file execution unit: single-cycle ALU ops, multi-cycle MUL
// through seq_mul, and RET which halts the unit until reset.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready                 instruction handshake
//   in_op, in_dst, in_src,
//   in_use_imm, in_imm                instruction fields (A = reg[dst], B = imm or reg[src])
//   wb_valid, wb_idx, wb_data         one-cycle write-back report after every write
//   halted                            RET has retired
//   rd_idx, rd_data                   combinational debug read port
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter  int unsigned WIDTH      = DEF_WIDTH,
    parameter  int unsigned NREGS      = DEF_NREGS,
    parameter  int unsigned MUL_LO_IDX = 0,
    parameter  int unsigned MUL_HI_IDX = 2,
    localparam int unsigned RW         = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [RW-1:0]     in_dst,
    input  logic [RW-1:0]     in_src,
    input  logic              in_use_imm,
    input  logic [WIDTH-1:0]  in_imm,
    output logic              wb_valid,
    output logic [RW-1:0]     wb_idx,
    output logic [WIDTH-1:0]  wb_data,
    output logic              halted,
    input  logic [RW-1:0]     rd_idx,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned    CW     = $clog2(WIDTH);
    localparam logic [RW-1:0]  LO_IDX = RW'(MUL_LO_IDX);
    localparam logic [RW-1:0]  HI_IDX = RW'(MUL_HI_IDX);

    state_t            state_q,    state_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic              wb_valid_q, wb_valid_d;
    logic [RW-1:0]     wb_idx_q,   wb_idx_d;
    logic [WIDTH-1:0]  wb_data_q,  wb_data_d;
    logic              ready_q,    ready_d;
    logic              halted_q,   halted_d;

    op_t               op_c;
    logic              accept_c;
    logic              mul_start_c;
    logic [WIDTH-1:0]  opnd_a_c;
    logic [WIDTH-1:0]  opnd_b_c;
    logic [WIDTH-1:0]  alu_c;
    logic              mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Operand fetch from pre-edge register state.
    assign op_c        = op_t'(in_op);
    assign accept_c    = in_valid && ready_q;
    assign mul_start_c = accept_c && (op_c == OP_MUL);
    assign opnd_a_c    = regs_q[in_dst];
    assign opnd_b_c    = in_use_imm ? in_imm : regs_q[in_src];

    // Single-cycle ALU; results wrap modulo 2^WIDTH.
    always_comb begin
        alu_c = '0;
        case (op_c)
            OP_ADD:  alu_c = opnd_a_c + opnd_b_c;
            OP_SUB:  alu_c = opnd_a_c - opnd_b_c;
            OP_AND:  alu_c = opnd_a_c & opnd_b_c;
            OP_OR:   alu_c = opnd_a_c | opnd_b_c;
            OP_XOR:  alu_c = opnd_a_c ^ opnd_b_c;
            OP_MOV:  alu_c = opnd_b_c;
            default: alu_c = '0;
        endcase
    end

    // Multiplier latches its operands on the accepting edge.
    seq_mul #(
        .WIDTH   (WIDTH)
    ) u_seq_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start_c),
        .a       (opnd_a_c),
        .b       (opnd_b_c),
        .done    (mul_done),
        .product (mul_product)
    );

    // Next-state, register-file writes and write-back report.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regs_d     = regs_q;
        wb_valid_d = 1'b0;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (op_is_alu(op_c)) begin
                        regs_d[in_dst] = alu_c;
                        wb_valid_d     = 1'b1;
                        wb_idx_d       = in_dst;
                        wb_data_d      = alu_c;
                    end else if (op_c == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = CW'(WIDTH - 1);
                    end else if (op_c == OP_RET) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_MUL: begin
                // Counter reaching zero coincides with seq_mul's done pulse.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (mul_done) begin
                        regs_d[HI_IDX] = mul_product[2*WIDTH-1:WIDTH];
                        regs_d[LO_IDX] = mul_product[WIDTH-1:0];
                        wb_valid_d     = 1'b1;
                        wb_idx_d       = LO_IDX;
                        wb_data_d      = mul_product[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d  = (state_d == ST_IDLE);
        halted_d = (state_d == ST_HALT);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            ready_q    <= 1'b1;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            regs_q     <= regs_d;
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
            ready_q    <= ready_d;
            halted_q   <= halted_d;
        end
    end

    assign in_ready = ready_q;
    assign wb_valid = wb_valid_q;
    assign wb_idx   = wb_idx_q;
    assign wb_data  = wb_data_q;
    assign halted   = halted_q;
    assign rd_data  = regs_q[rd_idx];

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, 64, datapath and register width in bits (>=8, even).
REQ-002 Parameter NREGS, 16, register-file entries (power of two, >=4); RW = log2(NREGS).
REQ-003 Parameter MUL_LO_IDX, 0, register receiving the low half of a MUL product.
REQ-004 Parameter MUL_HI_IDX, 2, register receiving the high half of a MUL product (!= MUL_LO_IDX).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  instruction offered this cycle.
REQ-008 in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-009 in_op  in  4  op_t opcode.
REQ-010 in_dst  in  RW  destination register, also source A.
REQ-011 in_src  in  RW  source B register index.
REQ-012 in_use_imm  in  1  source B is in_imm instead of register in_src.
REQ-013 in_imm  in  WIDTH  immediate value.
REQ-014 wb_valid  out  1  one-cycle pulse in the cycle after any register write.
REQ-015 wb_idx  out  RW  register written (for MUL: MUL_LO_IDX).
REQ-016 wb_data  out  WIDTH  value written (for MUL: low half).
REQ-017 halted  out  1  RET retired; unit idle until reset.
REQ-018 rd_idx  in  RW  debug read index.
REQ-019 rd_data  out  WIDTH  combinational contents of register rd_idx.

Function
REQ-020 Ops: NOP(0), ADD, SUB, AND, OR, XOR, MOV, MUL, RET; A = reg[in_dst]; B = in_use_imm ? in_imm : reg[in_src].
REQ-021 ADD/SUB/AND/OR/XOR write reg[in_dst] = A op B, modulo 2^WIDTH (wrap, no flags); MOV writes reg[in_dst] = B.
REQ-022 Single-cycle ops write the register file on the accepting edge; result visible on rd_data in the next cycle; in_ready stays 1 (throughput one per cycle).
REQ-023 Operands are sampled from register state before the accepting edge; back-to-back dependent ops see the previous result (no hazard).
REQ-024 NOP and undefined opcodes are accepted with no register write and no wb_valid pulse.
REQ-025 FSM states IDLE, MUL, HALT; reset state IDLE; in_ready = (state == IDLE).
REQ-026 MUL: unsigned WIDTH x WIDTH -> 2*WIDTH product, computed by an iterative shift-add over exactly WIDTH cycles in state MUL.
REQ-027 IDLE -> MUL on accepting MUL; operands latched at that edge; cycle counter loaded with WIDTH-1.
REQ-028 In MUL, on the edge where the counter equals 0, write reg[MUL_HI_IDX] = product[2W-1:W] and reg[MUL_LO_IDX] = product[W-1:0] simultaneously, then MUL -> IDLE; otherwise decrement.
REQ-029 MUL latency: accept edge E0, results written at edge E0+WIDTH; in_ready is 0 for exactly WIDTH cycles.
REQ-030 If in_dst or in_src equals MUL_LO_IDX/MUL_HI_IDX, the latched operand values are used; register changes during MUL cannot occur (no accepts).
REQ-031 RET: IDLE -> HALT on accept; halted = 1 from the next cycle; HALT is absorbing; no register writes.
REQ-032 in_valid while in_ready = 0 has no effect; the offerer holds the instruction (not checked).

Reset
REQ-033 reset_n low asynchronously forces state IDLE, all registers 0, counter 0, wb_valid 0, wb_idx 0, wb_data 0, halted 0; in_ready = 1 after release.
REQ-034 Reset asserted mid-MUL abandons the multiply with no write to MUL_LO_IDX/MUL_HI_IDX.

Structure
REQ-035 op_t enum and the state type shall live in the shared decoder-types package; WIDTH/NREGS defaults shall be package constants.
REQ-036 The iterative multiplier shall be a sub-module seq_mul (start, a, b -> done, product) instantiated once.

Verification
REQ-037 MOV r1,#0xFF; ADD r1,#1 (WIDTH=8) -> reg1 = 0x00, wb_valid pulses twice, wb_data 0xFF then 0x00.
REQ-038 Back-to-back MOV r3,#5; SUB r3,#7 (WIDTH=64) -> reg3 = 0xFFFF_FFFF_FFFF_FFFE one cycle after second accept.
REQ-039 MOV r4,#0xFFFF_FFFF_FFFF_FFFF; MUL r4,r4 -> in_ready low exactly 64 cycles; reg2 = 0xFFFF_FFFF_FFFF_FFFE, reg0 = 0x1.
REQ-040 in_valid held high with ADD during MUL -> ADD accepted only in first cycle in_ready = 1, applied once.
REQ-041 reset_n pulsed low 10 cycles into MUL r5,#3 -> all registers 0, in_ready 1 next cycle, no wb_valid.
REQ-042 RET then ADD r1,#1 -> halted = 1, in_ready = 0, reg1 unchanged.
